// File: rtl/allwordsame_arbiter.sv
// rtl/allwordsame_arbiter.sv - two-lane round-robin front end sharing one 256-bit all-word-same detector
module allwordsame_arbiter #(
    parameter int TAG_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [255:0]         req0_data_i,
    input  logic [TAG_WIDTH-1:0] req0_tag_i,
    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [255:0]         req1_data_i,
    input  logic [TAG_WIDTH-1:0] req1_tag_i,
    output logic                 rsp0_valid_o,
    input  logic                 rsp0_ready_i,
    output logic                 rsp0_same_o,
    output logic [TAG_WIDTH-1:0] rsp0_tag_o,
    output logic                 rsp1_valid_o,
    input  logic                 rsp1_ready_i,
    output logic                 rsp1_same_o,
    output logic [TAG_WIDTH-1:0] rsp1_tag_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] chk_cnt_o,
    output logic [CNT_WIDTH-1:0] same_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]                  req_valid;
    logic [1:0]                  rsp_ready;
    logic [1:0]                  rsp_hs;
    logic [1:0]                  eligible;
    logic [1:0]                  grant;
    logic                        grant_id;
    logic                        any_grant;
    logic                        s1_same;

    logic [1:0]                  pending_q, pending_d;
    logic                        rr_q, rr_d;
    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_id_q, s1_id_d;
    logic [TAG_WIDTH-1:0]        s1_tag_q, s1_tag_d;
    logic [255:0]                s1_data_q, s1_data_d;
    logic [1:0]                  rsp_valid_q, rsp_valid_d;
    logic [1:0]                  rsp_same_q, rsp_same_d;
    logic [1:0][TAG_WIDTH-1:0]   rsp_tag_q, rsp_tag_d;
    logic [CNT_WIDTH-1:0]        chk_cnt_q, chk_cnt_d;
    logic [CNT_WIDTH-1:0]        same_cnt_q, same_cnt_d;

    assign req_valid = {req1_valid_i, req0_valid_i};
    assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
    assign rsp_hs    = rsp_valid_q & rsp_ready;

    // A lane whose result is being consumed this cycle may be accepted again (bypass).
    assign eligible  = req_valid & (~pending_q | rsp_hs);

    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            if (eligible == 2'b11) begin
                grant = rr_q ? 2'b10 : 2'b01;
            end else begin
                grant = eligible;
            end
        end
    end

    assign grant_id  = grant[1];
    assign any_grant = |grant;
    assign s1_same   = (s1_data_q == {8{s1_data_q[255:224]}});

    always_comb begin
        rr_d        = any_grant ? ~grant_id : rr_q;
        pending_d   = (pending_q & ~rsp_hs) | grant;
        s1_valid_d  = any_grant;
        s1_id_d     = s1_id_q;
        s1_tag_d    = s1_tag_q;
        s1_data_d   = s1_data_q;
        if (any_grant) begin
            s1_id_d   = grant_id;
            s1_tag_d  = grant_id ? req1_tag_i : req0_tag_i;
            s1_data_d = grant_id ? req1_data_i : req0_data_i;
        end

        rsp_valid_d = rsp_valid_q & ~rsp_hs;
        rsp_same_d  = rsp_same_q;
        rsp_tag_d   = rsp_tag_q;
        chk_cnt_d   = chk_cnt_q;
        same_cnt_d  = same_cnt_q;
        if (s1_valid_q) begin
            rsp_valid_d[s1_id_q] = 1'b1;
            rsp_same_d[s1_id_q]  = s1_same;
            rsp_tag_d[s1_id_q]   = s1_tag_q;
            if (chk_cnt_q != CNT_MAX) begin
                chk_cnt_d = chk_cnt_q + CNT_ONE;
            end
            if (s1_same && (same_cnt_q != CNT_MAX)) begin
                same_cnt_d = same_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 2'b00;
            rr_q        <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= 1'b0;
            s1_tag_q    <= '0;
            s1_data_q   <= '0;
            rsp_valid_q <= 2'b00;
            rsp_same_q  <= 2'b00;
            rsp_tag_q   <= '0;
            chk_cnt_q   <= '0;
            same_cnt_q  <= '0;
        end else begin
            pending_q   <= pending_d;
            rr_q        <= rr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_tag_q    <= s1_tag_d;
            s1_data_q   <= s1_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_same_q  <= rsp_same_d;
            rsp_tag_q   <= rsp_tag_d;
            chk_cnt_q   <= chk_cnt_d;
            same_cnt_q  <= same_cnt_d;
        end
    end

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign rsp0_valid_o = rsp_valid_q[0];
    assign rsp1_valid_o = rsp_valid_q[1];
    assign rsp0_same_o  = rsp_same_q[0];
    assign rsp1_same_o  = rsp_same_q[1];
    assign rsp0_tag_o   = rsp_tag_q[0];
    assign rsp1_tag_o   = rsp_tag_q[1];
    assign busy_o       = |pending_q;
    assign chk_cnt_o    = chk_cnt_q;
    assign same_cnt_o   = same_cnt_q;

endmodule

// File: tb/tb_allwordsame_arbiter.sv
// tb/tb_allwordsame_arbiter.sv - scoreboard bench for allwordsame_arbiter
module tb_allwordsame_arbiter;

    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready_o, req1_ready_o;
    logic [255:0]  req0_data, req1_data;
    logic [3:0]    req0_tag, req1_tag;
    logic          rsp0_valid_o, rsp1_valid_o, rsp0_ready, rsp1_ready;
    logic          rsp0_same_o, rsp1_same_o, busy_o;
    logic [3:0]    rsp0_tag_o, rsp1_tag_o;
    logic [CW-1:0] chk_cnt_o, same_cnt_o;

    typedef struct packed {
        logic       same;
        logic [3:0] tag;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         tot_lines = 0;
    int         tot_same = 0;
    bit         rand_rdy = 1'b0;
    bit         held_v[2];
    logic       held_s[2];
    logic [3:0] held_t[2];

    allwordsame_arbiter #(.TAG_WIDTH(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready_o),
        .req0_data_i(req0_data), .req0_tag_i(req0_tag),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready_o),
        .req1_data_i(req1_data), .req1_tag_i(req1_tag),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready),
        .rsp0_same_o(rsp0_same_o), .rsp0_tag_o(rsp0_tag_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready),
        .rsp1_same_o(rsp1_same_o), .rsp1_tag_o(rsp1_tag_o),
        .busy_o(busy_o), .chk_cnt_o(chk_cnt_o), .same_cnt_o(same_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic model_same(input logic [255:0] d);
        logic [31:0] w[8];
        for (int k = 0; k < 8; k++) w[k] = d[255-32*k -: 32];
        for (int k = 1; k < 8; k++) if (w[k] != w[0]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [31:0]  w = $urandom;
        logic [255:0] one = 256'd1;
        logic [255:0] d = {8{w}};
        case ($urandom_range(0, 2))
            1: d = d ^ (one << $urandom_range(0, 255));
            2: for (int k = 0; k < 8; k++) d[255-32*k -: 32] = $urandom;
            default: ;
        endcase
        return d;
    endfunction

    function automatic void mon_lane(input int lane, input logic v, input logic r,
                                     input logic s, input logic [3:0] t);
        exp_t e;
        if (held_v[lane]) begin
            chk("hold_valid", 32'(v), 32'd1);
            chk("hold_same", 32'(s), 32'(held_s[lane]));
            chk("hold_tag", 32'(t), 32'(held_t[lane]));
        end
        if (v && r) begin
            if ((lane == 0 ? q0.size() : q1.size()) == 0) begin
                chk("unexpected_rsp", 32'(lane), 32'hFFFF);
            end else begin
                e = (lane == 0) ? q0.pop_front() : q1.pop_front();
                chk(lane == 0 ? "rsp0_same" : "rsp1_same", 32'(s), 32'(e.same));
                chk(lane == 0 ? "rsp0_tag" : "rsp1_tag", 32'(t), 32'(e.tag));
            end
        end
        held_v[lane] = v && !r;
        held_s[lane] = s;
        held_t[lane] = t;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            held_v[0] = 1'b0;
            held_v[1] = 1'b0;
        end else begin
            mon_lane(0, rsp0_valid_o, rsp0_ready, rsp0_same_o, rsp0_tag_o);
            mon_lane(1, rsp1_valid_o, rsp1_ready, rsp1_same_o, rsp1_tag_o);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send(input int lane, input logic [255:0] d, input logic [3:0] t);
        exp_t e;
        bit   got = 1'b0;
        e.same = model_same(d);
        e.tag  = t;
        if (lane == 0) begin req0_data = d; req0_tag = t; req0_valid = 1'b1; end
        else           begin req1_data = d; req1_tag = t; req1_valid = 1'b1; end
        for (int c = 0; c < 500 && !got; c++) begin
            @(negedge clk);
            if (!rst && (lane == 0 ? req0_ready_o : req1_ready_o)) begin
                got = 1'b1;
                if (lane == 0) q0.push_back(e); else q1.push_back(e);
                tot_lines++;
                tot_same += int'(e.same);
            end
            @(posedge clk);
            #1;
        end
        if (lane == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (!got) chk("send_timeout", 32'(lane), 32'hFFFF);
    endtask

    task automatic drain();
        bit done = 1'b0;
        rand_rdy   = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && busy_o == 1'b0) done = 1'b1;
        end
        chk("drain_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic random_lane(input int lane, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(lane, rand_line(), 4'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int g1;
        logic [255:0] line_a;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; req0_tag = '0; req1_tag = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
        chk("rst_valid", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
        chk("rst_same", 32'({rsp1_same_o, rsp0_same_o}), 32'd0);
        chk("rst_tag", 32'({rsp1_tag_o, rsp0_tag_o}), 32'd0);
        chk("rst_cnt", 32'({chk_cnt_o, same_cnt_o}), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        line_a = {8{32'hDEADBEEF}};
        send(0, line_a, 4'd3);
        @(negedge clk);
        chk("t1_valid_n1", 32'(rsp0_valid_o), 32'd0);
        @(negedge clk);
        chk("t1_valid_n2", 32'(rsp0_valid_o), 32'd1);
        chk("t1_same", 32'(rsp0_same_o), 32'd1);
        chk("t1_tag", 32'(rsp0_tag_o), 32'd3);
        @(posedge clk);
        #1;
        drain();
        chk("t1_chk_cnt", 32'(chk_cnt_o), 32'd1);
        chk("t1_same_cnt", 32'(same_cnt_o), 32'd1);

        send(1, {{7{32'hDEADBEEF}}, 32'hDEADBEEE}, 4'd5);
        drain();
        chk("t2_chk_cnt", 32'(chk_cnt_o), 32'd2);
        chk("t2_same_cnt", 32'(same_cnt_o), 32'd1);

        fork
            for (int i = 0; i < 9; i++) send(0, rand_line(), 4'(i));
            for (int i = 0; i < 9; i++) send(1, rand_line(), 4'(i + 8));
        join_none
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t3_grant", 32'({req1_ready_o, req0_ready_o}), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        wait fork;
        drain();

        rsp0_ready = 1'b0;
        send(0, rand_line(), 4'hA);
        fork
            for (int i = 0; i < 12; i++) send(1, rand_line(), 4'(i));
            send(0, rand_line(), 4'hB);
        join_none
        g1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_req0_blocked", 32'(req0_ready_o), 32'd0);
            g1 += int'(req1_ready_o);
        end
        chk("t4_lane1_rate", 32'(g1), 32'd5);
        @(posedge clk);
        #1;
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("t4_bypass_accept", 32'(req0_ready_o), 32'd1);
        @(posedge clk);
        #1;
        wait fork;
        drain();

        rand_rdy = 1'b1;
        fork
            random_lane(0, 600);
            random_lane(1, 600);
        join
        drain();
        chk("t5_chk_cnt_sat", 32'(chk_cnt_o), 32'((tot_lines > CMAX) ? CMAX : tot_lines));
        chk("t5_same_cnt", 32'(same_cnt_o), 32'((tot_same > CMAX) ? CMAX : tot_same));

        rsp1_ready = 1'b0;
        send(1, rand_line(), 4'h6);
        @(posedge clk);
        #1;
        send(0, rand_line(), 4'h7);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("t6_pre_rsp1_valid", 32'(rsp1_valid_o), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_valids", 32'({rsp1_valid_o, rsp0_valid_o}), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_chk_cnt", 32'(chk_cnt_o), 32'd0);
        chk("t6_same_cnt", 32'(same_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp1_ready = 1'b1;
        tot_lines = 0;
        tot_same = 0;
        fork
            send(0, rand_line(), 4'h1);
            send(1, rand_line(), 4'h2);
        join_none
        @(negedge clk);
        chk("t6_first_grant", 32'({req1_ready_o, req0_ready_o}), 32'd1);
        @(posedge clk);
        #1;
        wait fork;
        drain();
        chk("t6_post_chk_cnt", 32'(chk_cnt_o), 32'(tot_lines));
        chk("t6_post_same_cnt", 32'(same_cnt_o), 32'(tot_same));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
